// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl - multi-cycle sequencer for the single-issue NPC core.
//
// Owns the architectural PC, fetches one instruction at a time over a
// valid/ready request port, decodes the supported RV32I subset (auipc, lui,
// jal, jalr, addi, ebreak), drives the external combinational ALU and commits
// its results to the GPR file and the PC. Halts on ebreak, an illegal
// instruction, a fetch timeout or a misaligned next PC.
//
// Ports:
//   clk, rst_n                core clock, asynchronous active-low reset
//   ifu_req_valid/ready       fetch request handshake, ifu_addr = pc
//   ifu_rsp_valid, ifu_rdata  fetch response
//   alu_op/imm/pc, rs1_addr   operands for the combinational ALU
//   alu_next_pc, alu_result   ALU outputs, sampled at the end of EXEC
//   rf_wen/waddr/wdata        GPR write port (single-cycle pulse in WB)
//   pc, retire                architectural PC and commit pulse
//   halted, halt_code         sticky halt: 1 ebreak, 2 illegal, 3 bus fault
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rdata,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [4:0]  rs1_addr,
    input  logic [31:0] alu_next_pc,
    input  logic [31:0] alu_result,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_code
);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_EXEC     = 3'd3,
        S_WB       = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [31:0] EBREAK_C  = 32'h0010_0073;
    localparam logic [9:0]  TIMEOUT_C = 10'(FETCH_TIMEOUT);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [9:0]  r_cnt;
    logic        r_req_valid;
    logic [4:0]  r_alu_op;
    logic [31:0] r_alu_imm;
    logic [31:0] r_result;
    logic [31:0] r_next_pc;
    logic        r_rf_wen;
    logic        r_retire;
    logic        r_halted;
    logic [1:0]  r_halt_code;

    // One-hot ALU opcode for a raw instruction word; zero for ebreak/illegal.
    function automatic logic [4:0] f_decode_op(input logic [31:0] w);
        logic [4:0] op;
        op = 5'b00000;
        case (w[6:0])
            7'b0010111: op = 5'b00001;
            7'b0110111: op = 5'b00010;
            7'b1101111: op = 5'b00100;
            7'b1100111: op = (w[14:12] == 3'b000) ? 5'b01000 : 5'b00000;
            7'b0010011: op = (w[14:12] == 3'b000) ? 5'b10000 : 5'b00000;
            default:    op = 5'b00000;
        endcase
        return op;
    endfunction

    // Immediate for a raw instruction word (U, J or I format by opcode).
    function automatic logic [31:0] f_decode_imm(input logic [31:0] w);
        logic [31:0] imm;
        imm = 32'h0000_0000;
        case (w[6:0])
            7'b0010111, 7'b0110111: imm = {w[31:12], 12'h000};
            7'b1101111: imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            7'b1100111, 7'b0010011: imm = {{20{w[31]}}, w[31:20]};
            default:    imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    // Sequencer FSM: all state and all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_pc        <= RESET_PC;
            r_ir        <= 32'h0000_0000;
            r_cnt       <= 10'd0;
            r_req_valid <= 1'b0;
            r_alu_op    <= 5'b00000;
            r_alu_imm   <= 32'h0000_0000;
            r_result    <= 32'h0000_0000;
            r_next_pc   <= 32'h0000_0000;
            r_rf_wen    <= 1'b0;
            r_retire    <= 1'b0;
            r_halted    <= 1'b0;
            r_halt_code <= 2'd0;
        end else begin
            // Commit strobes are single-cycle unless re-armed below.
            r_rf_wen <= 1'b0;
            r_retire <= 1'b0;
            case (r_state)
                S_RESET: begin
                    r_state     <= S_FETCH;
                    r_req_valid <= 1'b1;
                end
                S_FETCH: begin
                    // Responses are ignored here; only the request handshake matters.
                    if (ifu_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= 10'd0;
                        r_state     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    // A response on the timeout cycle takes priority over the fault.
                    if (ifu_rsp_valid) begin
                        r_ir      <= ifu_rdata;
                        r_alu_op  <= f_decode_op(ifu_rdata);
                        r_alu_imm <= f_decode_imm(ifu_rdata);
                        r_state   <= S_EXEC;
                    end else if (r_cnt == TIMEOUT_C) begin
                        r_halted    <= 1'b1;
                        r_halt_code <= 2'd3;
                        r_state     <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_EXEC: begin
                    r_alu_op <= 5'b00000;
                    if (r_alu_op != 5'b00000) begin
                        r_result  <= alu_result;
                        r_next_pc <= alu_next_pc;
                        r_state   <= S_WB;
                        // Strobes are armed now so they are visible during WB;
                        // a misaligned target suppresses both.
                        if (alu_next_pc[1:0] == 2'b00) begin
                            r_rf_wen <= (r_ir[11:7] != 5'd0);
                            r_retire <= 1'b1;
                        end
                    end else begin
                        r_halted    <= 1'b1;
                        r_halt_code <= (r_ir == EBREAK_C) ? 2'd1 : 2'd2;
                        r_state     <= S_HALT;
                    end
                end
                S_WB: begin
                    if (r_next_pc[1:0] != 2'b00) begin
                        r_halted    <= 1'b1;
                        r_halt_code <= 2'd3;
                        r_state     <= S_HALT;
                    end else begin
                        r_pc        <= r_next_pc;
                        r_req_valid <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

    assign ifu_req_valid = r_req_valid;
    assign ifu_addr      = r_pc;
    assign alu_op        = r_alu_op;
    assign alu_imm       = r_alu_imm;
    assign alu_pc        = r_pc;
    assign rs1_addr      = r_ir[19:15];
    assign rf_wen        = r_rf_wen;
    assign rf_waddr      = r_ir[11:7];
    assign rf_wdata      = r_result;
    assign pc            = r_pc;
    assign retire        = r_retire;
    assign halted        = r_halted;
    assign halt_code     = r_halt_code;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
module tb_npc_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 8;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic [4:0]  alu_op;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [4:0]  rs1_addr;
    logic [31:0] alu_next_pc;
    logic [31:0] alu_result;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        retire;
    logic        halted;
    logic [1:0]  halt_code;

    int n_checks = 0;
    int n_fail   = 0;

    npc_seq_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .alu_op(alu_op), .alu_imm(alu_imm), .alu_pc(alu_pc), .rs1_addr(rs1_addr),
        .alu_next_pc(alu_next_pc), .alu_result(alu_result),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .retire(retire), .halted(halted), .halt_code(halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Reset, release, and stop on the first negedge with FETCH visible.
    task automatic do_reset();
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rdata = 32'h0;
        alu_result = 32'h0; alu_next_pc = 32'h0;
        step(); rst_n = 1'b0; step(); step();
        rst_n = 1'b1; step();
    endtask

    // From FETCH: handshake immediately, respond next cycle; ends with EXEC visible.
    task automatic do_fetch(input logic [31:0] instr);
        for (int i = 0; i < 10 && ifu_req_valid !== 1'b1; i++) step();
        n_checks++;
        if (ifu_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL fetch_wait: ifu_req_valid=%b expected 1", ifu_req_valid);
        end
        ifu_req_ready = 1'b1; step();
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rdata = instr; step();
        ifu_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rdata = 32'h0;
        alu_result = 32'h0; alu_next_pc = 32'h0;
        rst_n = 1'b0; step(); step();
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", pc, RST_PC); end
        n_checks++; if ({ifu_req_valid, rf_wen, retire, halted} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_ctl: got %b expected 0000", {ifu_req_valid, rf_wen, retire, halted}); end
        n_checks++; if ({alu_op, halt_code} !== 7'd0) begin
            n_fail++; $display("FAIL rst_op_code: got %b expected 0", {alu_op, halt_code}); end
        rst_n = 1'b1; step();
        n_checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC) begin
            n_fail++; $display("FAIL rst_first_fetch: valid=%b addr=%h expected 1 %h", ifu_req_valid, ifu_addr, RST_PC); end
    endtask

    task automatic test_addi();
        do_fetch(32'h0010_0093);
        n_checks++; if (alu_op !== 5'b10000 || alu_imm !== 32'd1) begin
            n_fail++; $display("FAIL addi_dec: op=%b imm=%h expected 10000 1", alu_op, alu_imm); end
        n_checks++; if (alu_pc !== RST_PC || rs1_addr !== 5'd0 || retire !== 1'b0) begin
            n_fail++; $display("FAIL addi_exec: pc=%h rs1=%0d retire=%b", alu_pc, rs1_addr, retire); end
        alu_result = 32'd1; alu_next_pc = 32'h8000_0004; step();
        n_checks++; if ({rf_wen, retire} !== 2'b11 || rf_waddr !== 5'd1 || rf_wdata !== 32'd1) begin
            n_fail++; $display("FAIL addi_wb: wen/ret=%b waddr=%0d wdata=%h expected 11 1 1", {rf_wen, retire}, rf_waddr, rf_wdata); end
        step();
        n_checks++; if (pc !== 32'h8000_0004 || {rf_wen, retire} !== 2'b00) begin
            n_fail++; $display("FAIL addi_commit: pc=%h wen/ret=%b expected 80000004 00", pc, {rf_wen, retire}); end
    endtask

    task automatic test_lui();
        do_fetch(32'h1234_5037);
        n_checks++; if (alu_op !== 5'b00010 || alu_imm !== 32'h1234_5000) begin
            n_fail++; $display("FAIL lui_dec: op=%b imm=%h expected 00010 12345000", alu_op, alu_imm); end
        alu_result = 32'h1234_5000; alu_next_pc = 32'h8000_0008; step();
        n_checks++; if ({rf_wen, retire} !== 2'b01) begin
            n_fail++; $display("FAIL lui_wb_rd0: wen/ret=%b expected 01", {rf_wen, retire}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [2];
        logic [31:0] val   [2];
        logic [4:0]  rd    [2];
        instr[0] = 32'h0050_0113; val[0] = 32'd5; rd[0] = 5'd2;
        instr[1] = 32'h0070_0193; val[1] = 32'd7; rd[1] = 5'd3;
        for (int k = 0; k < 2; k++) begin
            do_fetch(instr[k]);
            n_checks++; if (alu_imm !== val[k]) begin
                n_fail++; $display("FAIL b2b_imm%0d: got %h expected %h", k, alu_imm, val[k]); end
            alu_result = val[k]; alu_next_pc = pc + 32'd4; step();
            n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== rd[k] || rf_wdata !== val[k]) begin
                n_fail++; $display("FAIL b2b_wb%0d: wen=%b waddr=%0d wdata=%h", k, rf_wen, rf_waddr, rf_wdata); end
            step();
        end
        n_checks++; if (pc !== 32'h8000_0010 || ifu_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_pc: pc=%h valid=%b expected 80000010 1", pc, ifu_req_valid); end
    endtask

    task automatic test_jal();
        do_fetch(32'hFF9F_F0EF);
        n_checks++; if (alu_op !== 5'b00100 || alu_imm !== 32'hFFFF_FFF8 || alu_pc !== 32'h8000_0010) begin
            n_fail++; $display("FAIL jal_dec: op=%b imm=%h pc=%h", alu_op, alu_imm, alu_pc); end
        alu_result = 32'h8000_0014; alu_next_pc = 32'h8000_0008; step();
        n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h8000_0014) begin
            n_fail++; $display("FAIL jal_wb: wen=%b waddr=%0d wdata=%h", rf_wen, rf_waddr, rf_wdata); end
        step();
        n_checks++; if (pc !== 32'h8000_0008) begin
            n_fail++; $display("FAIL jal_pc: got %h expected 80000008", pc); end
    endtask

    task automatic test_ebreak();
        logic bad;
        do_fetch(32'h0010_0073);
        n_checks++; if (alu_op !== 5'b00000) begin
            n_fail++; $display("FAIL ebreak_op: got %b expected 00000", alu_op); end
        step();
        n_checks++; if (halted !== 1'b1 || halt_code !== 2'd1 || pc !== 32'h8000_0008) begin
            n_fail++; $display("FAIL ebreak_halt: halted=%b code=%0d pc=%h", halted, halt_code, pc); end
        bad = 1'b0; ifu_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ifu_req_valid !== 1'b0 || retire !== 1'b0 || rf_wen !== 1'b0 || halt_code !== 2'd1) bad = 1'b1;
            step();
        end
        ifu_req_ready = 1'b0;
        n_checks++; if (bad !== 1'b0) begin
            n_fail++; $display("FAIL ebreak_frozen: activity after halt flag=%b expected 0", bad); end
    endtask

    task automatic test_illegal();
        do_reset();
        do_fetch(32'hFFFF_FFFF);
        step();
        n_checks++; if (halted !== 1'b1 || halt_code !== 2'd2 || pc !== RST_PC) begin
            n_fail++; $display("FAIL illegal: halted=%b code=%0d pc=%h", halted, halt_code, pc); end
    endtask

    task automatic test_stall_timeout();
        logic bad;
        do_reset();
        bad = 1'b0;
        ifu_rsp_valid = 1'b1; ifu_rdata = 32'h0010_0093;
        for (int i = 0; i < 20; i++) begin
            if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC || retire !== 1'b0) bad = 1'b1;
            step();
        end
        ifu_rsp_valid = 1'b0;
        n_checks++; if (bad !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: request not held flag=%b expected 0", bad); end
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            if (halted !== 1'b0 || ifu_req_valid !== 1'b0) bad = 1'b1;
            step();
        end
        n_checks++; if (bad !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: premature halt flag=%b expected 0", bad); end
        n_checks++; if (halted !== 1'b1 || halt_code !== 2'd3 || pc !== RST_PC) begin
            n_fail++; $display("FAIL timeout_fault: halted=%b code=%0d pc=%h", halted, halt_code, pc); end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        for (int k = 0; k < TO; k++) step();
        ifu_rsp_valid = 1'b1; ifu_rdata = 32'h0010_0093; step();
        ifu_rsp_valid = 1'b0;
        n_checks++; if (halted !== 1'b0 || alu_op !== 5'b10000) begin
            n_fail++; $display("FAIL edge_rsp_wins: halted=%b op=%b expected 0 10000", halted, alu_op); end
        alu_result = 32'd1; alu_next_pc = 32'h8000_0004; step();
        n_checks++; if (retire !== 1'b1 || rf_wen !== 1'b1) begin
            n_fail++; $display("FAIL edge_retire: retire=%b wen=%b expected 1 1", retire, rf_wen); end
        step();
    endtask

    task automatic test_misaligned();
        do_fetch(32'h0001_00E7);
        n_checks++; if (alu_op !== 5'b01000 || rs1_addr !== 5'd2 || alu_imm !== 32'd0) begin
            n_fail++; $display("FAIL jalr_dec: op=%b rs1=%0d imm=%h", alu_op, rs1_addr, alu_imm); end
        alu_result = 32'h8000_0008; alu_next_pc = 32'h8000_0002; step();
        n_checks++; if (rf_wen !== 1'b0 || retire !== 1'b0) begin
            n_fail++; $display("FAIL misalign_wb: wen=%b retire=%b expected 0 0", rf_wen, retire); end
        step();
        n_checks++; if (halted !== 1'b1 || halt_code !== 2'd3 || pc !== 32'h8000_0004) begin
            n_fail++; $display("FAIL misalign_halt: halted=%b code=%0d pc=%h", halted, halt_code, pc); end
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        do_fetch(32'h0010_0093);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (alu_op !== 5'b00000 || halted !== 1'b0 || ifu_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_rst: op=%b halted=%b valid=%b", alu_op, halted, ifu_req_valid); end
        alu_result = 32'd1; alu_next_pc = 32'h8000_0004;
        step();
        n_checks++; if (rf_wen !== 1'b0 || retire !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_commit: wen=%b retire=%b expected 0 0", rf_wen, retire); end
        rst_n = 1'b1; step();
        do_fetch(32'h0010_0093);
        n_checks++; if (alu_pc !== RST_PC) begin
            n_fail++; $display("FAIL restart_pc: got %h expected %h", alu_pc, RST_PC); end
        step();
        n_checks++; if (retire !== 1'b1 || rf_wdata !== 32'd1) begin
            n_fail++; $display("FAIL restart_wb: retire=%b wdata=%h", retire, rf_wdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_addi();
        test_lui();
        test_back_to_back();
        test_jal();
        test_ebreak();
        test_illegal();
        test_stall_timeout();
        test_timeout_edge();
        test_misaligned();
        test_reset_in_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
